wb_regfile_stage: RTL and testbench
===================================

// Module: wb_regfile_stage
//
// PURPOSE
// Consumer end of the MEM/WB pipeline register. It selects the writeback result,
// extracts and extends load data, and writes the result into the 32-entry integer
// register file. It serves the decode stage two read ports with same-cycle write
// bypass. It counts retired instructions (instret).
// Sits between the MEM/WB register outputs and the ID stage / hazard unit.
//
// PARAMETERS
// XLEN   32  datapath width
// NREGS  32  register count; x0 hardwired to zero
// CNT_W  64  retired-instruction counter width
//
// PORTS
// clk           in   1      rising-edge clock
// reset         in   1      synchronous, active-high reset
// valid_w       in   1      WB slot holds a real (non-bubble) instruction
// reg_write_w   in   1      instruction writes rd
// result_src_w  in   2      00 ALU, 01 load, 10 PC+4, 11 ImmExt
// funct3_w      in   3      load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
// alu_result_w  in   XLEN   ALU result / load address
// read_data_w   in   XLEN   raw 32-bit word from data memory
// pc_plus4_w    in   XLEN   PC+4 (JAL/JALR link)
// imm_ext_w     in   XLEN   extended immediate (LUI)
// rd_w          in   5      destination register
// rs1_d, rs2_d  in   5      decode-stage source register indices
// rd1_d, rd2_d  out  XLEN   source operand values
// result_w      out  XLEN   selected writeback value (to forwarding muxes)
// instret       out  CNT_W  retired-instruction count
//
// BEHAVIOUR
// - Result select (combinational): mux on result_src_w; load value per rules below.
// - Load extraction uses byte offset off = alu_result_w[1:0], little-endian:
//   - LB/LBU: byte at off, sign- or zero-extended.
//   - LH/LHU: half at off[1] (off[0] ignored), sign- or zero-extended.
//   - LW: full word; off ignored.
//   - Undefined funct3 (011/110/111): raw read_data_w.
// - Write enable we = valid_w & reg_write_w & (rd_w != 0) & !reset.
//   - When we is set: rf[rd_w] <= result_w on posedge clk.
//   - valid_w=0 (bubble) never writes, whatever reg_write_w is.
// - Read ports (combinational):
//   - rsN==0 -> 0.
//   - else if we & (rsN==rd_w) -> result_w (write-through bypass, same cycle).
//   - else rf[rsN].
//   - Both ports may hit the same register; both bypass.
// - While reset=1: rd1_d, rd2_d = 0; result_w still reflects its inputs.
// - Counter: instret <= instret + 1 on posedge clk when valid_w & !reset.
//   - Counts non-writing instructions too (stores, branches).
//   - Wraps from 2^CNT_W-1 to 0; no saturation, no flag.
// - Reset (synchronous, active-high), on posedge clk with reset=1:
//   - all rf entries <= 0; instret <= 0.
//   - a pending write in the same cycle is dropped; reset takes priority.
//   - mid-stream reset: the next cycle sees a clean all-zero state.
// - Latency: a write is visible through rf one cycle after the write edge, and
//   through the bypass in the write cycle itself. So rd*_d never returns stale
//   data for a producer in WB.
// - No X propagation: rf is fully initialised by reset; x0 is never stored.
//
// TESTING
// 1. Reset 1 cycle, then sweep rs1/rs2 over 0..31 -> all reads 0; instret=0.
// 2. valid=1, reg_write=1, src=00, alu=0xDEADBEEF, rd=5, rs1=5 ->
//    rd1_d=0xDEADBEEF in the same cycle (bypass); next cycle with valid=0 -> rd1_d=0xDEADBEEF from rf.
// 3. Write rd=0, alu=0x1234, rs1=rs2=0 -> rd1_d=rd2_d=0, no bypass, rf unchanged.
// 4. read_data=0x80FF1234, src=01:
//    - LB, alu=0x..03 -> 0xFFFFFF80
//    - LBU -> 0x00000080
//    - LH, alu=0x..02 -> 0xFFFF80FF
//    - LHU -> 0x000080FF
//    - LW -> 0x80FF1234
// 5. 8 cycles, valid pattern 1,0,1,1,0,1,0,1, reg_write=0 -> instret=5, no rf change.
//    With CNT_W=4, 17 valid cycles -> instret=1 (wrap).
// 6. Load x7=0x55, then assert reset in the same cycle as a valid write x9=0xAA ->
//    after the edge x7=0, x9=0, instret=0, rd*_d=0 while reset is high.

Source files
------------

// File: rtl/wb_regfile_stage.sv
// Writeback stage: result select, load extraction, 32-entry integer
// register file with write-through read ports, and the instret counter.
module wb_regfile_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_w,
  input  logic             reg_write_w,
  input  logic [1:0]       result_src_w,
  input  logic [2:0]       funct3_w,
  input  logic [XLEN-1:0]  alu_result_w,
  input  logic [XLEN-1:0]  read_data_w,
  input  logic [XLEN-1:0]  pc_plus4_w,
  input  logic [XLEN-1:0]  imm_ext_w,
  input  logic [4:0]       rd_w,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  output logic [XLEN-1:0]  rd1_d,
  output logic [XLEN-1:0]  rd2_d,
  output logic [XLEN-1:0]  result_w,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0]  r_rf [NREGS];
  logic [CNT_W-1:0] r_instret;

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_load;
  logic             w_we;

  // pick the addressed byte / halfword out of the raw memory word
  always_comb begin
    w_byte = read_data_w[{alu_result_w[1:0], 3'b000} +: 8];
    w_half = alu_result_w[1] ? read_data_w[31:16]
                             : read_data_w[15:0];
  end

  // extend the loaded value according to the load type
  always_comb begin
    w_load = read_data_w;
    case (funct3_w)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b010:  w_load = read_data_w;
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = read_data_w;
    endcase
  end

  // writeback result mux
  always_comb begin
    result_w = alu_result_w;
    case (result_src_w)
      2'b00:   result_w = alu_result_w;
      2'b01:   result_w = w_load;
      2'b10:   result_w = pc_plus4_w;
      default: result_w = imm_ext_w;
    endcase
  end

  assign w_we = valid_w & reg_write_w
              & (rd_w != 5'd0) & ~reset;

  // read ports with same-cycle bypass of the WB write
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (!reset && rs1_d != 5'd0) begin
      if (w_we && rs1_d == rd_w) rd1_d = result_w;
      else                       rd1_d = r_rf[rs1_d];
    end
    if (!reset && rs2_d != 5'd0) begin
      if (w_we && rs2_d == rd_w) rd2_d = result_w;
      else                       rd2_d = r_rf[rs2_d];
    end
  end

  // register file storage; reset clears every entry and drops any write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_we) begin
      r_rf[rd_w] <= result_w;
    end
  end

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)        r_instret <= '0;
    else if (valid_w) r_instret <= r_instret + CNT_W'(1);
  end

  assign instret = r_instret;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Bench for wb_regfile_stage: vector table, directed sequences,
// and random traffic against an array-based reference model.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_w, reg_write_w;
  logic [1:0]  result_src_w;
  logic [2:0]  funct3_w;
  logic [31:0] alu_result_w, read_data_w, pc_plus4_w, imm_ext_w;
  logic [4:0]  rd_w, rs1_d, rs2_d;
  logic [31:0] rd1_d, rd2_d, result_w;
  logic [63:0] instret;
  logic [31:0] rd1_4, rd2_4, res_4;
  logic [3:0]  instret_4;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_rf [32];
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  wb_regfile_stage dut (
    .clk(clk), .reset(reset), .valid_w(valid_w),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .funct3_w(funct3_w), .alu_result_w(alu_result_w),
    .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w),
    .imm_ext_w(imm_ext_w), .rd_w(rd_w), .rs1_d(rs1_d),
    .rs2_d(rs2_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .result_w(result_w), .instret(instret)
  );

  wb_regfile_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .valid_w(valid_w),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .funct3_w(funct3_w), .alu_result_w(alu_result_w),
    .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w),
    .imm_ext_w(imm_ext_w), .rd_w(rd_w), .rs1_d(rs1_d),
    .rs2_d(rs2_d), .rd1_d(rd1_4), .rd2_d(rd2_4),
    .result_w(res_4), .instret(instret_4)
  );

  typedef struct {
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic cmp(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result();
    logic [31:0] b, h;
    b = (read_data_w >> (8 * alu_result_w[1:0])) & 32'hFF;
    h = (read_data_w >> (16 * alu_result_w[1])) & 32'hFFFF;
    case (result_src_w)
      2'd0: return alu_result_w;
      2'd2: return pc_plus4_w;
      2'd3: return imm_ext_w;
      default: begin
        case (funct3_w)
          3'b000: return b[7]  ? (b | 32'hFFFFFF00) : b;
          3'b001: return h[15] ? (h | 32'hFFFF0000) : h;
          3'b100: return b;
          3'b101: return h;
          default: return read_data_w;
        endcase
      end
    endcase
  endfunction

  function automatic logic model_we();
    return valid_w && reg_write_w && rd_w != 0 && !reset;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] rs);
    if (reset || rs == 0) return 32'h0;
    if (model_we() && rs == rd_w) return ref_result();
    return m_rf[rs];
  endfunction

  task automatic check_model();
    logic [31:0] e1, e2;
    e1 = ref_read(rs1_d);
    e2 = ref_read(rs2_d);
    cmp("result", {32'h0, result_w}, {32'h0, ref_result()});
    cmp("rd1", {32'h0, rd1_d}, {32'h0, e1});
    cmp("rd2", {32'h0, rd2_d}, {32'h0, e2});
    cmp("instret", instret, m_cnt);
    cmp("rd1_c4", {32'h0, rd1_4}, {32'h0, e1});
    cmp("rd2_c4", {32'h0, rd2_4}, {32'h0, e2});
    cmp("res_c4", {32'h0, res_4}, {32'h0, ref_result()});
    cmp("instret_c4", {60'h0, instret_4}, {60'h0, m_cnt[3:0]});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_cnt = 64'h0;
    end else begin
      if (model_we()) m_rf[rd_w] = ref_result();
      if (valid_w) m_cnt = m_cnt + 64'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; valid_w = 1'b0; reg_write_w = 1'b0;
    result_src_w = 2'd0; funct3_w = 3'd0;
    alu_result_w = 32'h0; read_data_w = 32'h0;
    pc_plus4_w = 32'h0; imm_ext_w = 32'h0;
    rd_w = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
  endtask

  initial begin
    tbl[0]  = '{2'd1, 3'b000, 32'h1003, 32'h80FF1234, 32'hFFFFFF80};
    tbl[1]  = '{2'd1, 3'b100, 32'h1003, 32'h80FF1234, 32'h00000080};
    tbl[2]  = '{2'd1, 3'b001, 32'h1002, 32'h80FF1234, 32'hFFFF80FF};
    tbl[3]  = '{2'd1, 3'b101, 32'h1002, 32'h80FF1234, 32'h000080FF};
    tbl[4]  = '{2'd1, 3'b010, 32'h1003, 32'h80FF1234, 32'h80FF1234};
    tbl[5]  = '{2'd1, 3'b000, 32'h1000, 32'h80FF1234, 32'h00000034};
    tbl[6]  = '{2'd1, 3'b100, 32'h1001, 32'h80FF1234, 32'h00000012};
    tbl[7]  = '{2'd1, 3'b000, 32'h1002, 32'h80FF1234, 32'hFFFFFFFF};
    tbl[8]  = '{2'd1, 3'b001, 32'h1003, 32'h80FF1234, 32'hFFFF80FF};
    tbl[9]  = '{2'd1, 3'b001, 32'h1001, 32'h80FF1234, 32'h00001234};
    tbl[10] = '{2'd1, 3'b011, 32'h1001, 32'h80FF1234, 32'h80FF1234};
    tbl[11] = '{2'd1, 3'b110, 32'h1002, 32'h80FF1234, 32'h80FF1234};

    for (int i = 0; i < 32; i++) m_rf[i] = 32'hX;
    m_cnt = 64'hX;
    idle();
    reset = 1'b1;
    @(negedge clk);
    tick();

    // reset sweep
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_d = 5'(i); rs2_d = 5'(31 - i);
      #1;
      cmp("sweep_rd1", {32'h0, rd1_d}, 64'h0);
      cmp("sweep_rd2", {32'h0, rd2_d}, 64'h0);
    end
    cmp("sweep_instret", instret, 64'h0);

    // bypass then rf read
    valid_w = 1'b1; reg_write_w = 1'b1; result_src_w = 2'd0;
    alu_result_w = 32'hDEADBEEF; rd_w = 5'd5; rs1_d = 5'd5;
    #1;
    cmp("bypass", {32'h0, rd1_d}, 64'hDEADBEEF);
    check_model();
    tick();
    valid_w = 1'b0; alu_result_w = 32'h0;
    #1;
    cmp("rf_read", {32'h0, rd1_d}, 64'hDEADBEEF);
    check_model();
    tick();

    // write to x0 is ignored
    valid_w = 1'b1; reg_write_w = 1'b1; rd_w = 5'd0;
    alu_result_w = 32'h1234; rs1_d = 5'd0; rs2_d = 5'd0;
    #1;
    cmp("x0_rd1", {32'h0, rd1_d}, 64'h0);
    cmp("x0_rd2", {32'h0, rd2_d}, 64'h0);
    tick();
    valid_w = 1'b0;
    #1;
    cmp("x0_after", {32'h0, rd1_d}, 64'h0);
    check_model();

    // load extraction / result-select table
    for (int i = 0; i < 12; i++) begin
      valid_w = 1'b1; reg_write_w = 1'b1; rd_w = 5'd10;
      rs1_d = 5'd10; rs2_d = 5'd5;
      result_src_w = tbl[i].src; funct3_w = tbl[i].f3;
      alu_result_w = tbl[i].alu; read_data_w = tbl[i].rdata;
      #1;
      cmp("tbl_res", {32'h0, result_w}, {32'h0, tbl[i].exp});
      cmp("tbl_byp", {32'h0, rd1_d}, {32'h0, tbl[i].exp});
      check_model();
      tick();
    end
    result_src_w = 2'd2; pc_plus4_w = 32'h0000_2004;
    imm_ext_w = 32'hABCD_E000; rd_w = 5'd11; rs2_d = 5'd11;
    #1;
    cmp("pc4_byp", {32'h0, rd2_d}, 64'h2004);
    check_model();
    tick();
    result_src_w = 2'd3;
    #1;
    cmp("imm_byp", {32'h0, rd2_d}, 64'hABCDE000);
    check_model();
    tick();

    // instret counting pattern
    idle(); reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat;
      pat = 8'b1010_1101;
      valid_w = pat[i]; reg_write_w = 1'b0;
      rd_w = 5'd3; alu_result_w = 32'h77; rs1_d = 5'd3;
      #1;
      check_model();
      tick();
    end
    valid_w = 1'b0;
    #1;
    cmp("count5", instret, 64'd5);
    cmp("count5_rf", {32'h0, rd1_d}, 64'h0);

    // 4-bit counter wrap
    reset = 1'b1; tick(); reset = 1'b0;
    valid_w = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    valid_w = 1'b0;
    #1;
    cmp("wrap_c4", {60'h0, instret_4}, 64'd1);
    cmp("wrap_c64", instret, 64'd17);

    // reset wins over a same-cycle write
    valid_w = 1'b1; reg_write_w = 1'b1; result_src_w = 2'd0;
    rd_w = 5'd7; alu_result_w = 32'h55;
    tick();
    rd_w = 5'd9; alu_result_w = 32'hAA; reset = 1'b1;
    rs1_d = 5'd7; rs2_d = 5'd9;
    #1;
    cmp("rst_rd1", {32'h0, rd1_d}, 64'h0);
    cmp("rst_rd2", {32'h0, rd2_d}, 64'h0);
    cmp("rst_res", {32'h0, result_w}, 64'hAA);
    tick();
    reset = 1'b0; valid_w = 1'b0;
    #1;
    cmp("post_x7", {32'h0, rd1_d}, 64'h0);
    cmp("post_x9", {32'h0, rd2_d}, 64'h0);
    cmp("post_cnt", instret, 64'h0);
    check_model();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      valid_w = 1'($urandom);
      reg_write_w = ($urandom_range(0, 3) != 0);
      result_src_w = 2'($urandom);
      funct3_w = 3'($urandom);
      alu_result_w = $urandom;
      read_data_w = $urandom;
      pc_plus4_w = $urandom;
      imm_ext_w = $urandom;
      rd_w = 5'($urandom_range(0, 15));
      rs1_d = ($urandom_range(0, 2) == 0) ? rd_w
                                         : 5'($urandom_range(0, 15));
      rs2_d = ($urandom_range(0, 2) == 0) ? rd_w
                                         : 5'($urandom_range(0, 15));
      #1;
      check_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
